instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a combinational ROM and hands words to the decoder
// over a valid/ready handshake. Define FETCH_JAL_PREDECODE_EN to follow JAL targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 58
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_oob
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS * 4);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_oob_q, out_oob_d;

  logic        fetch_oob;
  logic [31:0] fetch_word;
  logic        load;
  logic [31:0] next_pc;
  logic        unused_redirect_lsbs;

  // Redirect targets are word aligned; the byte offset bits are dropped on purpose.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign rom_addr   = pc_q[9:2];
  assign fetch_oob  = (pc_q >= ROM_LIMIT);
  assign fetch_word = fetch_oob ? NOP_INSTR : rom_instr;

  // A slot is free when nothing is held or the held word leaves this edge.
  assign load = (state_q == RUN) && (!out_valid_q || out_ready) && !redirect_valid;

`ifdef FETCH_JAL_PREDECODE_EN
  function automatic logic signed [31:0] jal_offset(input logic [31:0] w);
    logic signed [31:0] imm;
    imm = $signed({{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0});
    return imm;
  endfunction

  logic        is_jal;
  logic [31:0] jal_target;

  assign is_jal     = (fetch_word[6:0] == 7'b1101111);
  assign jal_target = pc_q + $unsigned(jal_offset(fetch_word));
  assign next_pc    = is_jal ? jal_target : (pc_q + 32'd4);
`else
  assign next_pc = pc_q + 32'd4;
`endif

  always_comb begin
    state_d     = fetch_en ? RUN : IDLE;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_oob_d   = out_oob_q;

    if (redirect_valid) begin
      out_valid_d = 1'b0;
      pc_d        = {redirect_pc[31:2], 2'b00};
    end else if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = fetch_word;
      out_pc_d    = pc_q;
      out_oob_d   = fetch_oob;
      pc_d        = next_pc;
    end else if ((state_q == IDLE) && out_valid_q && out_ready) begin
      // Draining while paused: the decoder takes the last word, nothing replaces it.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 32'h0000_0000;
      out_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_oob_q   <= out_oob_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_oob   = out_oob_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboarded streaming, stall/redirect/reset
// sequences, and a vector table for IDLE/RUN handshake corners.
module tb_instr_fetch;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'd232;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_oob;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .ROM_WORDS(58)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
    .rom_instr(rom_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_oob(out_oob)
  );

  // Team ROM: word 0 is addi x1,x0,21; word 44 is JAL x0,+4; word 57 is JAL x0,0.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h0150_0093;
      8'd44:   return 32'h0040_006F;
      8'd57:   return 32'h0000_006F;
      default: return {8'hA5, a, 16'h1234};
    endcase
  endfunction

  assign rom_instr = rom_word(rom_addr);

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return (pc >= LIMIT) ? NOP : rom_word(pc[9:2]);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [31:0] w;
    w = exp_word(pc);
`ifdef FETCH_JAL_PREDECODE_EN
    if (w[6:0] == 7'b1101111)
      return pc + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
`endif
    return pc + 32'd4;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        oob;
  } sb_item_t;

  sb_item_t sb_q[$];

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_oob;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [31:0] start, input int n);
    logic [31:0] p;
    sb_item_t it;
    p = start;
    for (int i = 0; i < n; i++) begin
      it.pc    = p;
      it.instr = exp_word(p);
      it.oob   = (p >= LIMIT);
      sb_q.push_back(it);
      p = model_next(p);
    end
  endtask

  // Pops an expected item whenever the decoder takes a word at the coming edge.
  task automatic sb_check();
    sb_item_t it;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h expected no output", out_pc);
      end else begin
        it = sb_q.pop_front();
        check("sb_pc", out_pc, it.pc);
        check("sb_instr", out_instr, it.instr);
        check("sb_oob", {31'b0, out_oob}, {31'b0, it.oob});
      end
    end
  endtask

  task automatic cyc(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    sb_check();
    step();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 8'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 8'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 8'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 32'h0,         1'b0, 8'd8};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 8'd8};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h20,        1'b0, 8'd9};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h24,        1'b0, 8'd10};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h24,        1'b0, 8'hFF};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 8'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 8'd1};

    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, NOP);
    check("rst_pc", out_pc, 32'h0);
    check("rst_oob", {31'b0, out_oob}, 32'd0);
    check("rst_addr", {24'b0, rom_addr}, 32'd0);

    // Start-up latency and steady streaming.
    rst_n = 1'b1;
    push_expect(32'h0, 5);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    check("word0", out_instr, 32'h0150_0093);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // Five-cycle stall at pc 12.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_pc", out_pc, 32'd12);
      check("stall_instr", out_instr, rom_word(8'd3));
      check("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("after_stall_pc", out_pc, 32'd16);

    // Redirect during a stall.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall16_pc", out_pc, 32'd16);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_00B3);
    check("redir_flush_valid", {31'b0, out_valid}, 32'd0);
    sb_q.delete();
    push_expect(32'h0000_00B0, 16);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_target_valid", {31'b0, out_valid}, 32'd1);
    check("redir_target_pc", out_pc, 32'h0000_00B0);
    check("redir_target_instr", out_instr, rom_word(8'd44));
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_JAL_PREDECODE_EN
    check("jal_self_pc", out_pc, 32'h0000_00E4);
    check("jal_self_oob", {31'b0, out_oob}, 32'd0);
`else
    check("oob_pc", out_pc, 32'h0000_00E8);
    check("oob_instr", out_instr, NOP);
    check("oob_flag", {31'b0, out_oob}, 32'd1);
`endif
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-stream, no clock edge involved.
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_pc", out_pc, 32'h0);
    check("async_rst_instr", out_instr, NOP);
    check("async_rst_addr", {24'b0, rom_addr}, 32'd0);
    sb_q.delete();
    fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      fetch_en       = vecs[i].fe;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      step();
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_addr", i), {24'b0, rom_addr}, {24'b0, vecs[i].exp_addr});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_oob", i), {31'b0, out_oob}, {31'b0, vecs[i].exp_oob});
        check($sformatf("vec%0d_instr", i), out_instr, exp_word(vecs[i].exp_pc));
      end
    end

    // Reset landing on a pending redirect discards both the held word and the target.
    fetch_en = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    #2;
    rst_n = 1'b0;
    step();
    check("rst_redir_valid", {31'b0, out_valid}, 32'd0);
    check("rst_redir_addr", {24'b0, rom_addr}, 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("rst_redir_lat1", {31'b0, out_valid}, 32'd0);
    step();
    check("rst_redir_first_valid", {31'b0, out_valid}, 32'd1);
    check("rst_redir_first_pc", out_pc, 32'h0);
    check("rst_redir_first_instr", out_instr, 32'h0150_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
